// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants, types and helpers for the tick generator.
//   CNT_W_DEF       - default counter/divisor width
//   DEFAULT_DIV_DEF - default terminal count loaded at reset
//   CNT_W_MAX       - widest counter a channel can be built with
//   sel_width()     - width of the channel-select bus for a given channel count
//   chan_state_t    - per-channel state record (count, active/shadow divisor, pend)
package tick_gen_pkg;

  localparam int CNT_W_DEF       = 14;
  localparam int DEFAULT_DIV_DEF = 4999;
  localparam int CNT_W_MAX       = 32;

  // A one-channel build still needs a 1-bit select bus.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Fields are CNT_W_MAX wide so one record type serves every CNT_W; bits
  // above the configured width are held at zero and fold away as constants.
  typedef struct packed {
    logic [CNT_W_MAX-1:0] count;
    logic [CNT_W_MAX-1:0] act_div;
    logic [CNT_W_MAX-1:0] shd_div;
    logic                 pend;
  } chan_state_t;

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one divider channel.
//   clk, reset  - clock and synchronous active-high reset
//   en          - run enable; low freezes count and square
//   restart     - synchronous phase restart (count and square to 0)
//   wr          - divisor write addressed to this channel (already decoded)
//   wr_data     - new terminal count
//   tick        - registered one-cycle strobe at wrap
//   square      - registered output toggling at each wrap
//   pend        - shadow divisor written but not yet applied
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tick,
  output logic             square,
  output logic             pend
);

  localparam logic [CNT_W_MAX-1:0] RST_DIV = CNT_W_MAX'(CNT_W'(DEFAULT_DIV));

  chan_state_t          state_q, state_d;
  logic                 tick_q, tick_d;
  logic                 square_q, square_d;
  logic                 wrap;
  logic                 apply;
  logic [CNT_W_MAX-1:0] wr_ext;

  assign wr_ext = CNT_W_MAX'(wr_data);

  // '>=' rather than '==': a smaller divisor applied while the channel was
  // frozen can leave count above act_div, and that must still wrap.
  assign wrap  = en && !restart && (state_q.count >= state_q.act_div);

  // Points where no phase is in progress, so a divisor change cannot glitch.
  assign apply = restart || !en || wrap;

  always_comb begin
    state_d  = state_q;
    tick_d   = 1'b0;
    square_d = square_q;

    if (restart) begin
      state_d.count = '0;
      square_d      = 1'b0;
    end else if (en) begin
      if (wrap) begin
        state_d.count = '0;
        tick_d        = 1'b1;
        square_d      = ~square_q;
      end else begin
        state_d.count = state_q.count + 1'b1;
      end
    end

    if (apply) begin
      if (wr) begin
        // Write coincident with an apply point bypasses the shadow.
        state_d.act_div = wr_ext;
        state_d.shd_div = wr_ext;
        state_d.pend    = 1'b0;
      end else if (state_q.pend) begin
        state_d.act_div = state_q.shd_div;
        state_d.pend    = 1'b0;
      end
    end else if (wr) begin
      state_d.shd_div = wr_ext;
      state_d.pend    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= '{count: '0, act_div: RST_DIV, shd_div: RST_DIV, pend: 1'b0};
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick   = tick_q;
  assign square = square_q;
  assign pend   = state_q.pend;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: parametrised multi-channel tick generator.
//   clk_50   - system clock
//   reset    - synchronous active-high reset
//   en       - per-channel run enable
//   restart  - per-channel synchronous phase restart
//   div_wr   - divisor write strobe
//   div_sel  - channel addressed by div_wr
//   div_data - new terminal count
//   div_ack  - one-cycle acknowledge of an accepted write
//   pending  - per-channel shadow divisor not yet applied
//   tick     - per-channel one-cycle strobe at wrap
//   square   - per-channel output toggling at each wrap
//
// Write handshake: div_wr is a single-cycle strobe with no back-pressure; a
// write is accepted in the cycle div_wr is high if div_sel < CHANNELS, and
// div_ack is high exactly one cycle later. Out-of-range writes are dropped
// silently with no ack.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                           clk_50,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            en,
  input  logic [CHANNELS-1:0]            restart,
  input  logic                           div_wr,
  input  logic [sel_width(CHANNELS)-1:0] div_sel,
  input  logic [CNT_W-1:0]               div_data,
  output logic                           div_ack,
  output logic [CHANNELS-1:0]            pending,
  output logic [CHANNELS-1:0]            tick,
  output logic [CHANNELS-1:0]            square
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic wr_valid;
  logic ack_q, ack_d;

  assign wr_valid = div_wr && ({1'b0, div_sel} < CH_LIM);

  always_comb begin
    ack_d = wr_valid;
  end

  always_ff @(posedge clk_50) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= ack_d;
  end

  assign div_ack = ack_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    tick_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk_50),
      .reset   (reset),
      .en      (en[i]),
      .restart (restart[i]),
      .wr      (wr_valid && (div_sel == SEL_W'(i))),
      .wr_data (div_data),
      .tick    (tick[i]),
      .square  (square[i]),
      .pend    (pending[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed bench for tick_gen with DEFAULT_DIV=4.
// A second 3-channel instance exercises an out-of-range channel select.
module tb_tick_gen;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [3:0]  en, restart;
  logic        div_wr;
  logic [1:0]  div_sel;
  logic [13:0] div_data;
  logic        div_ack;
  logic [3:0]  pending, tick, square;

  logic [2:0]  en_b, restart_b;
  logic        wr_b;
  logic [1:0]  sel_b;
  logic [13:0] data_b;
  logic        ack_b;
  logic [2:0]  pending_b, tick_b, square_b;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk_50 = ~clk_50;

  tick_gen #(.CHANNELS(4), .CNT_W(14), .DEFAULT_DIV(4)) u_dut (
    .clk_50 (clk_50), .reset (reset), .en (en), .restart (restart),
    .div_wr (div_wr), .div_sel (div_sel), .div_data (div_data),
    .div_ack (div_ack), .pending (pending), .tick (tick), .square (square)
  );

  tick_gen #(.CHANNELS(3), .CNT_W(14), .DEFAULT_DIV(4)) u_dut_b (
    .clk_50 (clk_50), .reset (reset), .en (en_b), .restart (restart_b),
    .div_wr (wr_b), .div_sel (sel_b), .div_data (data_b),
    .div_ack (ack_b), .pending (pending_b), .tick (tick_b), .square (square_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge to sample and drive.
  task automatic edge1();
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = '0; restart = '0; div_wr = 1'b0; div_sel = '0; div_data = '0;
    en_b = '0; restart_b = '0; wr_b = 1'b0; sel_b = '0; data_b = '0;
    edge1();
    edge1();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_t, exp_s;
    logic       t_oth, t1;

    // A: reset state, then free-running period 5 / square period 10
    @(negedge clk_50);
    do_reset();
    check("A rst tick", 32'(tick), 'h0);
    check("A rst square", 32'(square), 'h0);
    check("A rst pending", 32'(pending), 'h0);
    check("A rst ack", 32'(div_ack), 'h0);
    en = 4'hF;
    for (int n = 1; n <= 15; n++) begin
      edge1();
      exp_t = (n % 5 == 0) ? 4'hF : 4'h0;
      exp_s = (((n / 5) % 2) == 1) ? 4'hF : 4'h0;
      check($sformatf("A tick e%0d", n), 32'(tick), 32'(exp_t));
      check($sformatf("A square e%0d", n), 32'(square), 32'(exp_s));
    end

    // B: write div 2 to ch1 mid-period; old period finishes, then period 3
    do_reset();
    en = 4'hF;
    edge1();
    edge1();
    div_wr = 1'b1; div_sel = 2'd1; div_data = 14'd2;
    edge1();
    check("B ack", 32'(div_ack), 'h1);
    check("B pending", 32'(pending), 'h2);
    div_wr = 1'b0;
    edge1();
    check("B ack low", 32'(div_ack), 'h0);
    check("B pending held", 32'(pending), 'h2);
    edge1();
    check("B wrap tick", 32'(tick), 'hF);
    check("B pending clr", 32'(pending), 'h0);
    for (int n = 6; n <= 11; n++) begin
      edge1();
      t_oth = (n == 10);
      t1    = (n == 8) || (n == 11);
      check($sformatf("B tick e%0d", n), 32'(tick), 32'({t_oth, t_oth, t1, t_oth}));
    end

    // C: restart ch0 on its wrap cycle
    do_reset();
    en = 4'hF;
    for (int n = 1; n <= 4; n++) edge1();
    restart = 4'b0001;
    edge1();
    check("C restart tick", 32'(tick), 'hE);
    check("C restart square", 32'(square), 'hE);
    restart = 4'b0000;
    for (int n = 6; n <= 9; n++) edge1();
    check("C e9 tick", 32'(tick), 'h0);
    edge1();
    check("C e10 tick", 32'(tick), 'hF);
    check("C e10 square", 32'(square), 'h1);

    // D: ch2 frozen for 7 cycles at count 2
    do_reset();
    en = 4'hF;
    edge1();
    edge1();
    en = 4'b1011;
    for (int n = 3; n <= 9; n++) begin
      edge1();
      check($sformatf("D frozen tick e%0d", n), 32'(tick), (n == 5) ? 'hB : 'h0);
    end
    en = 4'hF;
    edge1();
    check("D e10 tick", 32'(tick), 'hB);
    edge1();
    check("D e11 tick", 32'(tick), 'h0);
    edge1();
    check("D e12 tick", 32'(tick), 'h4);
    check("D e12 square", 32'(square), 'h4);

    // E: div 0 written to disabled ch3 (bypass), then enabled
    do_reset();
    en = 4'b0111;
    div_wr = 1'b1; div_sel = 2'd3; div_data = 14'd0;
    edge1();
    check("E ack", 32'(div_ack), 'h1);
    check("E pending", 32'(pending), 'h0);
    div_wr = 1'b0;
    en = 4'hF;
    edge1();
    check("E e2 tick", 32'(tick), 'h8);
    check("E e2 square", 32'(square), 'h8);
    edge1();
    check("E e3 tick", 32'(tick), 'h8);
    check("E e3 square", 32'(square), 'h0);
    edge1();
    check("E e4 tick", 32'(tick), 'h8);
    check("E e4 square", 32'(square), 'h8);
    edge1();
    check("E e5 tick", 32'(tick), 'hF);
    check("E e5 square", 32'(square), 'h7);

    // F: out-of-range select on the 3-channel instance is ignored
    do_reset();
    en_b = 3'b111;
    wr_b = 1'b1; sel_b = 2'd3; data_b = 14'd0;
    edge1();
    check("F ack", 32'(ack_b), 'h0);
    check("F pending", 32'(pending_b), 'h0);
    wr_b = 1'b0;
    for (int n = 2; n <= 5; n++) begin
      edge1();
      check($sformatf("F tick e%0d", n), 32'(tick_b), (n == 5) ? 'h7 : 'h0);
    end
    check("F square", 32'(square_b), 'h7);

    // G: reset with pending writes on every channel
    do_reset();
    en = 4'hF;
    div_wr = 1'b1; div_data = 14'd1;
    for (int c = 0; c < 4; c++) begin
      div_sel = 2'(c);
      edge1();
    end
    check("G pending all", 32'(pending), 'hF);
    check("G ack", 32'(div_ack), 'h1);
    div_wr = 1'b0;
    reset = 1'b1;
    edge1();
    check("G rst tick", 32'(tick), 'h0);
    check("G rst square", 32'(square), 'h0);
    check("G rst pending", 32'(pending), 'h0);
    check("G rst ack", 32'(div_ack), 'h0);
    reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      edge1();
      check($sformatf("G post tick e%0d", n), 32'(tick), (n == 5) ? 'hF : 'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
